// File: rtl/vga_fb_read_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_read_arbiter
//   Shares one single-port frame-buffer SRAM between the VGA display read
//   stream and a host pixel writer. Sequential pixels are prefetched into a
//   small FIFO and handed to the VGA controller one cycle after each request.
//
// Ports
//   iCLK, iRST        pixel clock, synchronous active-high reset
//   iFRAME_START      frame-start pulse: flush FIFO, rewind read address
//   iRequest          display pop strobe (one pixel per asserted cycle)
//   oPixel            pixel for the previous-cycle pop (0 on underflow)
//   oUnderflow        sticky per frame: a pop found the FIFO empty
//   iWR_REQ/ADDR/DATA host write request, held until oWR_ACK
//   oWR_ACK           one-cycle pulse: host write issued this cycle
//   oSRAM_*           SRAM address / write data / write / read strobes
//   iSRAM_RDATA       read data, valid the cycle after oSRAM_RE
// ---------------------------------------------------------------------------
module vga_fb_read_arbiter #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int FRAME_PIX  = 480000,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iFRAME_START,
    input  logic              iRequest,
    output logic [DATA_W-1:0] oPixel,
    output logic              oUnderflow,
    input  logic              iWR_REQ,
    input  logic [ADDR_W-1:0] iWR_ADDR,
    input  logic [DATA_W-1:0] iWR_DATA,
    output logic              oWR_ACK,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    output logic [DATA_W-1:0] oSRAM_WDATA,
    output logic              oSRAM_WE,
    output logic              oSRAM_RE,
    input  logic [DATA_W-1:0] iSRAM_RDATA
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   pix_q, pix_d;
    logic                unf_q, unf_d;
    logic                pend_q, pend_d;
    logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

    logic                pop, push;
    logic [CNT_W:0]      occ;

    // Outputs are decodes of registered state, so they change only on clk.
    assign oSRAM_RE    = (state_q == READ);
    assign oSRAM_WE    = (state_q == WRITE);
    assign oWR_ACK     = (state_q == WRITE);
    assign oSRAM_ADDR  = addr_q;
    assign oSRAM_WDATA = wdata_q;
    assign oPixel      = pix_q;
    assign oUnderflow  = unf_q;

    always_comb begin
        pop  = iRequest && (count_q != '0);
        // pend_q marks a read issued last cycle: its data is on iSRAM_RDATA now.
        push = pend_q;
        // Occupancy counts stored words plus both reads still in the SRAM
        // pipeline (the one landing now and the one issued this cycle), so a
        // full FIFO can never be overrun. It ignores the current pop, which
        // only errs on the side of reading less.
        occ  = {1'b0, count_q} + (CNT_W+1)'(pend_q) + (CNT_W+1)'(state_q == READ);

        if (iFRAME_START)                            state_d = IDLE;
        else if (occ < (CNT_W+1)'(LOW_WM))           state_d = READ;
        else if (iWR_REQ && state_q != WRITE)        state_d = WRITE;
        else if (occ < (CNT_W+1)'(FIFO_DEPTH))       state_d = READ;
        else                                         state_d = IDLE;

        rd_addr_d = rd_addr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_d)
            READ: begin
                addr_d    = rd_addr_q;
                rd_addr_d = (rd_addr_q == ADDR_W'(FRAME_PIX - 1)) ? '0
                                                                   : rd_addr_q + ADDR_W'(1);
            end
            WRITE: begin
                addr_d  = iWR_ADDR;
                wdata_d = iWR_DATA;
            end
            default: ;
        endcase

        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        pend_d  = (state_q == READ) && !iFRAME_START;

        pix_d = pix_q;
        unf_d = unf_q;
        if (iRequest) begin
            pix_d = pop ? mem_q[head_q] : '0;
            if (!pop) unf_d = 1'b1;
        end

        // Frame start overrides pops, pushes and the in-flight read.
        if (iFRAME_START) begin
            rd_addr_d = '0;
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            pix_d     = '0;
            unf_d     = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pix_q     <= '0;
            unf_q     <= 1'b0;
            pend_q    <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            pix_q     <= pix_d;
            unf_q     <= unf_d;
            pend_q    <= pend_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge iCLK) begin
        if (!iRST && !iFRAME_START && push)
            mem_q[tail_q] <= iSRAM_RDATA;
    end
endmodule

// File: tb/tb_vga_fb_read_arbiter.sv
module tb_vga_fb_read_arbiter;
    localparam int FP = 1000;

    logic        clk, rst, fs, req, wr_req, wr_ack;
    logic        sram_we, sram_re, unf;
    logic [15:0] pixel, wr_data, sram_wdata, sram_rdata;
    logic [19:0] wr_addr, sram_addr;

    int n_chk, n_fail;
    int exp_rd, nrd, nwrap, last_rd, nack;
    logic prev_ack;
    bit got;

    vga_fb_read_arbiter #(.ADDR_W(20), .DATA_W(16), .FRAME_PIX(FP),
                          .FIFO_DEPTH(16), .LOW_WM(8)) dut (
        .iCLK(clk), .iRST(rst), .iFRAME_START(fs), .iRequest(req),
        .oPixel(pixel), .oUnderflow(unf),
        .iWR_REQ(wr_req), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data), .oWR_ACK(wr_ack),
        .oSRAM_ADDR(sram_addr), .oSRAM_WDATA(sram_wdata), .oSRAM_WE(sram_we),
        .oSRAM_RE(sram_re), .iSRAM_RDATA(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: read data equals the low address bits, one cycle later.
    always_ff @(posedge clk)
        sram_rdata <= sram_re ? sram_addr[15:0] : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Advance one cycle, sample 1ns after the edge, and watch the SRAM bus.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("we_re_excl", 32'(sram_we & sram_re), 32'd0);
        if (sram_re) begin
            chk("rd_addr", 32'(sram_addr), 32'(exp_rd));
            if (sram_addr == 20'd0 && last_rd == FP - 1) nwrap++;
            last_rd = int'(sram_addr);
            exp_rd  = (exp_rd == FP - 1) ? 0 : exp_rd + 1;
            nrd++;
        end
        if (wr_ack) chk("ack_gap", 32'(prev_ack), 32'd0);
        prev_ack = wr_ack;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; exp_rd = 0; nrd = 0; nwrap = 0; last_rd = -1;
        nack = 0; prev_ack = 1'b0;
        rst = 1'b1; fs = 1'b0; req = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;

        // 1: reset, then idle prefill of exactly 16 reads at 0..15
        repeat (3) tick();
        chk("rst_pixel", 32'(pixel), 32'd0);
        chk("rst_unf",   32'(unf), 32'd0);
        chk("rst_re",    32'(sram_re), 32'd0);
        chk("rst_we",    32'(sram_we), 32'd0);
        chk("rst_ack",   32'(wr_ack), 32'd0);
        chk("rst_addr",  32'(sram_addr), 32'd0);
        rst = 1'b0; nrd = 0; exp_rd = 0;
        repeat (20) tick();
        chk("prefill_reads", 32'(nrd), 32'd16);
        chk("prefill_idle",  32'(sram_re), 32'd0);
        chk("prefill_pixel", 32'(pixel), 32'd0);
        chk("prefill_unf",   32'(unf), 32'd0);

        // 2: 800 back-to-back pops return 0..799
        req = 1'b1;
        for (int k = 0; k < 800; k++) begin
            tick();
            chk("line_pixel", 32'(pixel), 32'(k));
        end
        req = 1'b0;
        chk("line_unf", 32'(unf), 32'd0);
        repeat (25) tick();

        // 3: host write against a full FIFO is issued on the next cycle
        wr_req = 1'b1; wr_addr = 20'h00123; wr_data = 16'hBEEF;
        tick();
        wr_req = 1'b0;
        chk("wr_ack",   32'(wr_ack), 32'd1);
        chk("wr_we",    32'(sram_we), 32'd1);
        chk("wr_re",    32'(sram_re), 32'd0);
        chk("wr_addr",  32'(sram_addr), 32'h00123);
        chk("wr_wdata", 32'(sram_wdata), 32'hBEEF);
        tick();
        chk("wr_ack_drop", 32'(wr_ack), 32'd0);

        // 4: continuous pops with the host always requesting
        wr_req = 1'b1; wr_addr = 20'h00200; wr_data = 16'h1000;
        req = 1'b1;
        for (int k = 0; k < 800; k++) begin
            tick();
            chk("mix_pixel", 32'(pixel), 32'((800 + k) % FP));
            if (wr_ack) begin
                chk("mix_wr_addr",  32'(sram_addr), 32'(wr_addr));
                chk("mix_wr_wdata", 32'(sram_wdata), 32'(wr_data));
                nack++;
                wr_addr = wr_addr + 20'd1;
                wr_data = wr_data + 16'd1;
            end
        end
        req = 1'b0; wr_req = 1'b0;
        chk("mix_unf", 32'(unf), 32'd0);
        chk("mix_some_writes", 32'(nack > 0), 32'd1);
        repeat (25) tick();

        // 5: pop straight after reset underflows; frame start clears it
        rst = 1'b1;
        tick();
        chk("rst2_re", 32'(sram_re), 32'd0);
        rst = 1'b0; req = 1'b1; exp_rd = 0;
        tick();
        req = 1'b0;
        chk("uf_pixel", 32'(pixel), 32'd0);
        chk("uf_flag",  32'(unf), 32'd1);
        repeat (3) tick();
        chk("uf_sticky", 32'(unf), 32'd1);
        fs = 1'b1; wr_req = 1'b1; wr_addr = 20'h00456; wr_data = 16'h1234;
        tick();
        fs = 1'b0; exp_rd = 0;
        chk("fs_unf", 32'(unf), 32'd0);
        chk("fs_re",  32'(sram_re), 32'd0);
        chk("fs_ack", 32'(wr_ack), 32'd0);
        tick();
        chk("fs_first_re", 32'(sram_re), 32'd1);
        chk("fs_first_addr", 32'(sram_addr), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (wr_ack) begin
                got = 1'b1;
                chk("fs_wr_addr", 32'(sram_addr), 32'h00456);
            end
        end
        wr_req = 1'b0;
        chk("fs_wr_kept", 32'(got), 32'd1);
        repeat (20) tick();
        req = 1'b1;
        tick();
        tick();
        chk("fs_pop2", 32'(pixel), 32'd1);
        fs = 1'b1;
        tick();
        fs = 1'b0; req = 1'b0; exp_rd = 0;
        chk("fs_req_pixel", 32'(pixel), 32'd0);
        chk("fs_req_unf",   32'(unf), 32'd0);

        // 6: read address wraps at FRAME_PIX-1; reset drops an in-flight read
        repeat (25) tick();
        nwrap = 0;
        req = 1'b1;
        for (int k = 0; k < 1010; k++) begin
            tick();
            chk("wrap_pixel", 32'(pixel), 32'(k % FP));
        end
        req = 1'b0;
        chk("wrap_seen", 32'(nwrap), 32'd1);
        repeat (25) tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (sram_re) got = 1'b1;
        end
        chk("inflight_issued", 32'(got), 32'd1);
        rst = 1'b1; exp_rd = 0;
        tick();
        rst = 1'b0; req = 1'b1;
        tick();
        req = 1'b0;
        chk("inflight_drop_unf",   32'(unf), 32'd1);
        chk("inflight_drop_pixel", 32'(pixel), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
